// File: rtl/zeroriscy_defines.sv
// Shared core definitions: multiplier/divider operator codes and the divider FSM state type.
package zeroriscy_defines;

  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX
  } div_state_e;

endpackage

// File: rtl/zeroriscy_div_unit_if.sv
// ID-stage <-> divider request/result bundle; names match the original divider ports.
interface zeroriscy_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_en_i;
  logic [1:0]       operator_i;
  logic             signed_mode_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic [WIDTH-1:0] result_o;
  logic             ready_o;

  modport master (
    output div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    input  result_o, ready_o
  );

  modport slave (
    input  div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/zeroriscy_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, 34-cycle fixed latency.
module zeroriscy_div_unit
  import zeroriscy_defines::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  zeroriscy_div_unit_if.slave  div_if
);

  div_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic                 b_zero_q, b_zero_d;
  logic                 rem_op_q, rem_op_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic [WIDTH:0]       add_x, add_y, add_res;
  logic                 add_sub;
  logic                 ge;
  logic                 neg;
  logic [WIDTH-1:0]     fix_val;
  logic [WIDTH-1:0]     result_mux;
  logic                 ready;

  // Single shared adder: 0-a in IDLE, trial subtract in CALC, 0-result in FIX.
  // A negative divisor is kept raw; its sign extension already equals -|b|.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        add_y   = {1'b0, div_if.op_a_i};
        add_sub = 1'b1;
      end
      DIV_CALC: begin
        add_x = {1'b0, rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        if (b_neg_q) begin
          add_y   = {1'b1, b_q};
          add_sub = 1'b0;
        end else begin
          add_y   = {1'b0, b_q};
          add_sub = 1'b1;
        end
      end
      DIV_FIX: begin
        add_y   = {1'b0, (rem_op_q ? rem_q : quo_q)};
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_res = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    b_d        = b_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    b_zero_d   = b_zero_q;
    rem_op_d   = rem_op_q;
    result_d   = result_q;
    result_mux = result_q;
    ready      = 1'b0;
    ge         = 1'b0;
    neg        = 1'b0;
    fix_val    = '0;

    case (state_q)
      DIV_IDLE: begin
        if (div_if.div_en_i) begin
          state_d  = DIV_CALC;
          cnt_d    = '1;
          rem_d    = '0;
          a_neg_d  = div_if.signed_mode_i & div_if.op_a_i[WIDTH-1];
          b_neg_d  = div_if.signed_mode_i & div_if.op_b_i[WIDTH-1];
          b_zero_d = (div_if.op_b_i == '0);
          rem_op_d = (div_if.operator_i == MD_OP_REM);
          b_d      = div_if.op_b_i;
          quo_d    = a_neg_d ? add_res[WIDTH-1:0] : div_if.op_a_i;
        end
      end
      DIV_CALC: begin
        if (!div_if.div_en_i) begin
          state_d = DIV_IDLE;
        end else begin
          // Shifted-out remainder MSB means the partial remainder already exceeds any divisor.
          ge    = rem_q[WIDTH-1] | ~add_res[WIDTH];
          rem_d = ge ? add_res[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == '0) state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = DIV_IDLE;
        if (div_if.div_en_i) begin
          neg        = rem_op_q ? a_neg_q : ((a_neg_q ^ b_neg_q) & ~b_zero_q);
          fix_val    = neg ? add_res[WIDTH-1:0] : (rem_op_q ? rem_q : quo_q);
          ready      = 1'b1;
          result_d   = fix_val;
          result_mux = fix_val;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      rem_op_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      rem_op_q <= rem_op_d;
      result_q <= result_d;
    end
  end

  assign div_if.result_o = result_mux;
  assign div_if.ready_o  = ready;

endmodule

// File: tb/tb_zeroriscy_div_unit.sv
// Directed bench for zeroriscy_div_unit: results, latency, corner cases, abort and reset.
module tb_zeroriscy_div_unit;
  import zeroriscy_defines::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  zeroriscy_div_unit_if #(.WIDTH(32)) div_if ();

  zeroriscy_div_unit #(.WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op and waits (bounded) for ready_o; lat counts edges from the request edge.
  task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat);
    bit done;
    @(negedge clk);
    div_if.div_en_i      = 1'b1;
    div_if.operator_i    = op;
    div_if.signed_mode_i = sgn;
    div_if.op_a_i        = a;
    div_if.op_b_i        = b;
    lat  = 0;
    done = 1'b0;
    res  = 'x;
    repeat (40) begin
      @(posedge clk);
      #1;
      lat++;
      if (div_if.ready_o) begin
        res  = div_if.result_o;
        done = 1'b1;
        break;
      end
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
    div_if.div_en_i = 1'b0;
    #1;
  endtask

  logic [31:0] r;
  int          lat;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    div_if.div_en_i      = 1'b0;
    div_if.operator_i    = MD_OP_DIV;
    div_if.signed_mode_i = 1'b0;
    div_if.op_a_i        = '0;
    div_if.op_b_i        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, div_if.ready_o}, 32'd0);
    chk("reset_result", div_if.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MD_OP_DIV, 1'b0, 32'd100, 32'd7, r, lat);
    chk("divu_100_7", r, 32'd14);
    chk("divu_latency", lat, 33);
    chk("ready_pulse_low", {31'b0, div_if.ready_o}, 32'd0);
    chk("result_hold", div_if.result_o, 32'd14);
    run_op(MD_OP_REM, 1'b0, 32'd100, 32'd7, r, lat);
    chk("remu_100_7", r, 32'd2);

    run_op(MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("div_m7_2", r, 32'hFFFF_FFFD);
    run_op(MD_OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("rem_m7_2", r, 32'hFFFF_FFFF);
    run_op(MD_OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, r, lat);
    chk("div_7_m2", r, 32'hFFFF_FFFD);
    run_op(MD_OP_REM, 1'b1, 32'd7, 32'hFFFF_FFFE, r, lat);
    chk("rem_7_m2", r, 32'd1);

    run_op(MD_OP_DIV, 1'b1, 32'h1234, 32'd0, r, lat);
    chk("div_1234_0", r, 32'hFFFF_FFFF);
    run_op(MD_OP_DIV, 1'b0, 32'h1234, 32'd0, r, lat);
    chk("divu_1234_0", r, 32'hFFFF_FFFF);
    run_op(MD_OP_REM, 1'b1, 32'h1234, 32'd0, r, lat);
    chk("rem_1234_0", r, 32'h1234);
    run_op(MD_OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, r, lat);
    chk("div_m5_0", r, 32'hFFFF_FFFF);
    run_op(MD_OP_REM, 1'b1, 32'hFFFF_FFFB, 32'd0, r, lat);
    chk("rem_m5_0", r, 32'hFFFF_FFFB);
    run_op(MD_OP_REM, 1'b0, 32'hFFFF_FFFB, 32'd0, r, lat);
    chk("remu_m5_0", r, 32'hFFFF_FFFB);

    run_op(MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    chk("div_ovf", r, 32'h8000_0000);
    run_op(MD_OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    chk("rem_ovf", r, 32'd0);
    run_op(MD_OP_DIV, 1'b1, 32'h8000_0000, 32'h8000_0000, r, lat);
    chk("div_min_min", r, 32'd1);

    run_op(MD_OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, r, lat);
    chk("divu_big", r, 32'd1);
    run_op(MD_OP_REM, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, r, lat);
    chk("remu_big", r, 32'h7FFF_FFFE);

    // Abort after 10 edges of an op, then a fresh DIVU 9/3.
    @(negedge clk);
    div_if.div_en_i      = 1'b1;
    div_if.operator_i    = MD_OP_DIV;
    div_if.signed_mode_i = 1'b0;
    div_if.op_a_i        = 32'd100;
    div_if.op_b_i        = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    div_if.div_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_ready", {31'b0, div_if.ready_o}, 32'd0);
    end
    run_op(MD_OP_DIV, 1'b0, 32'd9, 32'd3, r, lat);
    chk("abort_next_res", r, 32'd3);
    chk("abort_next_lat", lat, 33);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    div_if.div_en_i      = 1'b1;
    div_if.operator_i    = MD_OP_DIV;
    div_if.signed_mode_i = 1'b0;
    div_if.op_a_i        = 32'd100;
    div_if.op_b_i        = 32'd7;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, div_if.ready_o}, 32'd0);
    chk("arst_result", div_if.result_o, 32'd0);
    div_if.div_en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("arst_next_res", r, 32'hFFFF_FFFD);
    chk("arst_next_lat", lat, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
